// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives the imem handshake, buffers responses
// in a small queue and redirects on predictor flush/hit. FETCH_PERF_EN adds perf counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_br,
    input  logic        hit,
    input  logic [31:0] npc,
    input  logic        id_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid_IF,
    output logic [31:0] pc_IF,
    output logic [31:0] instr_IF
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_redirect_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);
    localparam int              PW        = $clog2(FQ_DEPTH);
    localparam int              CW        = PW + 1;
    localparam logic [31:0]     NOP       = 32'h0000_0013;
    localparam logic [6:0]      OP_BRANCH = 7'b1100011;
    localparam logic [PW-1:0]   PTR_ONE   = PW'(1);
    localparam logic [CW:0]     CAP       = (CW + 1)'(FQ_DEPTH);
    localparam logic [CW-1:0]   FULL_CNT  = CW'(FQ_DEPTH);

    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   fq_pc_q    [FQ_DEPTH];
    logic [31:0]   fq_pc_d    [FQ_DEPTH];
    logic [31:0]   fq_instr_q [FQ_DEPTH];
    logic [31:0]   fq_instr_d [FQ_DEPTH];
    logic [31:0]   pf_pc_q    [FQ_DEPTH];
    logic [31:0]   pf_pc_d    [FQ_DEPTH];
    logic [PW-1:0] fq_rd_q, fq_rd_d, fq_wr_q, fq_wr_d;
    logic [PW-1:0] pf_rd_q, pf_rd_d, pf_wr_q, pf_wr_d;
    logic [CW-1:0] fq_cnt_q, fq_cnt_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;

    logic          issue_s, gnt_s, resp_s, drop_resp_s, push_s, pop_s;
    logic          valid_s, head_br_s, hit_take_s, redirect_s;
    logic [CW-1:0] out_next_s;
    logic [31:0]   npc_al_s;

    // Handshake qualification and redirect arbitration (flush beats hit; hit waits for the branch to pop)
    always_comb begin
        issue_s     = !rst_i && (({1'b0, fq_cnt_q} + {1'b0, out_q}) < CAP);
        gnt_s       = issue_s && imem_gnt;
        resp_s      = imem_rvalid && (out_q != '0);
        drop_resp_s = resp_s && (drop_q != '0);
        valid_s     = (fq_cnt_q != '0);
        pop_s       = valid_s && id_ready;
        head_br_s   = (fq_instr_q[fq_rd_q][6:0] == OP_BRANCH);
        hit_take_s  = !flush_br && hit && pop_s && head_br_s;
        redirect_s  = flush_br || hit_take_s;
        npc_al_s    = npc & 32'hFFFF_FFFC;
        out_next_s  = out_q + CW'(gnt_s) - CW'(resp_s);
        push_s      = resp_s && !drop_resp_s && !redirect_s;
    end

    // Next-state for fetch PC, in-flight accounting and queue pointers
    always_comb begin
        fpc_d    = fpc_q;
        out_d    = out_next_s;
        drop_d   = drop_q;
        fq_rd_d  = fq_rd_q;
        fq_wr_d  = fq_wr_q;
        fq_cnt_d = fq_cnt_q;
        pf_rd_d  = resp_s ? pf_rd_q + PTR_ONE : pf_rd_q;
        pf_wr_d  = gnt_s  ? pf_wr_q + PTR_ONE : pf_wr_q;
        if (redirect_s) begin
            fpc_d    = npc_al_s;
            drop_d   = out_next_s;
            fq_rd_d  = '0;
            fq_wr_d  = '0;
            fq_cnt_d = '0;
        end else begin
            fpc_d    = gnt_s ? fpc_q + 32'd4 : fpc_q;
            drop_d   = drop_resp_s ? drop_q - CW'(1) : drop_q;
            fq_rd_d  = pop_s  ? fq_rd_q + PTR_ONE : fq_rd_q;
            fq_wr_d  = push_s ? fq_wr_q + PTR_ONE : fq_wr_q;
            fq_cnt_d = fq_cnt_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // Storage writes: issued-address FIFO and fetch-queue payload
    always_comb begin
        pf_pc_d    = pf_pc_q;
        fq_pc_d    = fq_pc_q;
        fq_instr_d = fq_instr_q;
        if (gnt_s) begin
            pf_pc_d[pf_wr_q] = fpc_q;
        end else begin
            pf_pc_d = pf_pc_q;
        end
        if (push_s) begin
            fq_pc_d[fq_wr_q]    = pf_pc_q[pf_rd_q];
            fq_instr_d[fq_wr_q] = imem_rdata;
        end else begin
            fq_instr_d = fq_instr_q;
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fpc_q    <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            fq_rd_q  <= '0;
            fq_wr_q  <= '0;
            fq_cnt_q <= '0;
            pf_rd_q  <= '0;
            pf_wr_q  <= '0;
        end else begin
            fpc_q    <= fpc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            fq_rd_q  <= fq_rd_d;
            fq_wr_q  <= fq_wr_d;
            fq_cnt_q <= fq_cnt_d;
            pf_rd_q  <= pf_rd_d;
            pf_wr_q  <= pf_wr_d;
        end
    end

    // Payload storage; contents are qualified by the pointers, so no reset needed
    always_ff @(posedge clk_i) begin
        pf_pc_q    <= pf_pc_d;
        fq_pc_q    <= fq_pc_d;
        fq_instr_q <= fq_instr_d;
    end

    assign imem_req  = issue_s;
    assign imem_addr = fpc_q;
    assign valid_IF  = valid_s;
    assign pc_IF     = valid_s ? fq_pc_q[fq_rd_q]    : RESET_PC;
    assign instr_IF  = valid_s ? fq_instr_q[fq_rd_q] : NOP;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_redirect_q, perf_redirect_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    // Counters wrap naturally at 2^32
    always_comb begin
        perf_redirect_d = perf_redirect_q + 32'(redirect_s);
        perf_bubble_d   = perf_bubble_q + 32'(!valid_s);
    end

    // Perf counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_redirect_q <= 32'd0;
            perf_bubble_q   <= 32'd0;
        end else begin
            perf_redirect_q <= perf_redirect_d;
            perf_bubble_q   <= perf_bubble_d;
        end
    end

    assign perf_redirect_cnt = perf_redirect_q;
    assign perf_bubble_cnt   = perf_bubble_q;
`endif

    fetch_unit_chk #(.CW(CW), .FULL_CNT(FULL_CNT)) u_chk (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (push_s),
        .fq_cnt_i (fq_cnt_q),
        .out_i    (out_q)
    );
endmodule

// Invariants of the fetch queue: never pushed while full, in-flight count bounded.
module fetch_unit_chk #(
    parameter int            CW       = 2,
    parameter logic [CW-1:0] FULL_CNT = '1
) (
    input logic          clk_i,
    input logic          rst_i,
    input logic          push_i,
    input logic [CW-1:0] fq_cnt_i,
    input logic [CW-1:0] out_i
);
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && (fq_cnt_i == FULL_CNT)));
    a_out_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        (out_i <= FULL_CNT));
endmodule
